ahb_cmd_master: RTL and testbench

- Single-master AHB-lite initiator sitting directly upstream of the SRAM controller (sramc_top) on the hclk domain.
- Converts a simple valid/ready command stream (read/write, addr, size, wdata) into AHB SINGLE NONSEQ transfers, pipelining the next address phase over the current data phase.
- Returns one response pulse per command carrying read data, error flag and a wait-state watchdog status. Replaces task-driven stimulus with a synthesizable front end (e.g. CPU bridge or self-test sequencer).

---
 rtl/ahb_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: single-master AHB-lite initiator that turns a valid/ready
// command stream into SINGLE NONSEQ transfers. The next address phase is
// pipelined over the current data phase.
// Optional build macro AHB_MST_ERR_RESP_EN: honour the two-cycle AHB ERROR
// response (cancel the pending address phase, retire the command with rsp_err).
module ahb_cmd_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timeout,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    output logic        hready,
    input  logic        hready_resp,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [31:0] ADDR_MASK     = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                          : 32'((64'd1 << ADDR_W) - 64'd1);
    localparam logic [15:0] TIMEOUT_LIM   = 16'(TIMEOUT_CYC);

    // Bit 1 = address phase occupied (a_vld), bit 0 = data phase occupied (d_vld)
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DATA      = 2'b01,
        ST_ADDR      = 2'b10,
        ST_ADDR_DATA = 2'b11
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        a_vld;
    logic        d_vld;
    logic        err_cyc;
    logic        advance;
    logic        accept;
    logic        a_next;
    logic        d_next;
    logic [1:0]  size_eff;
    logic [31:0] addr_aligned;
    logic [31:0] a_wdata;
    logic        d_write;
    logic [15:0] wd_cnt;

    assign a_vld  = state_q[1];
    assign d_vld  = state_q[0];
    assign hburst = 3'b000;
    assign hready = hready_resp;
    assign accept = cmd_valid & cmd_ready;

`ifdef AHB_MST_ERR_RESP_EN
    // Both ERROR cycles of the data phase hold the address phase back
    assign err_cyc = d_vld & (hresp == 2'b01);
`else
    logic unused_hresp;
    assign unused_hresp = ^hresp;
    assign err_cyc      = 1'b0;
`endif

    // The address phase only advances on a ready, non-error data phase
    assign advance = hready_resp & ~err_cyc;

    // Phase register: tracks which of the two pipeline stages hold a command
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase occupancy: A drains into D on advance, an ERROR retire empties D only
    always_comb begin
        a_next = a_vld | accept;
        d_next = d_vld;
        if (hready_resp) begin
            if (advance) begin
                d_next = a_vld;
                a_next = accept;
            end else begin
                d_next = 1'b0;
            end
        end
        state_d = state_t'({a_next, d_next});
    end

    // Bus-facing handshake and transfer type derived from the phase state
    always_comb begin
        cmd_ready = ~a_vld | advance;
        hsel      = a_vld & ~err_cyc;
        htrans    = hsel ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // Command decode: size 3 behaves as word, address aligned to the size
    always_comb begin
        size_eff = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        case (size_eff)
            2'd1:    addr_aligned = {cmd_addr[31:1], 1'b0};
            2'd2:    addr_aligned = {cmd_addr[31:2], 2'b00};
            default: addr_aligned = cmd_addr;
        endcase
    end

    // Address/control capture on acceptance, write data moves with A into D
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr   <= '0;
            hwrite  <= 1'b0;
            hsize   <= 3'b000;
            a_wdata <= '0;
            hwdata  <= '0;
            d_write <= 1'b0;
        end else begin
            if (advance && a_vld) begin
                d_write <= hwrite;
                if (hwrite) begin
                    hwdata <= a_wdata;
                end
            end
            if (accept) begin
                haddr   <= addr_aligned & ADDR_MASK;
                hwrite  <= cmd_write;
                hsize   <= {1'b0, size_eff};
                a_wdata <= cmd_wdata;
            end
        end
    end

    // One response pulse per completed data phase; writes and errors return zero data
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_vld & hready_resp;
            if (d_vld && hready_resp) begin
                rsp_err   <= err_cyc;
                rsp_rdata <= (d_write || err_cyc) ? 32'h0 : hrdata;
            end
        end
    end

    // Wait-state watchdog: counts a stalled data phase, flag stays set until reset
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (hready_resp) begin
            wd_cnt <= '0;
        end else if (d_vld) begin
            if (wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_cnt >= TIMEOUT_LIM - 16'd1) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed scenarios for ahb_cmd_master with a small
// word-addressed AHB slave memory model. Built with TIMEOUT_CYC=4.
module tb_ahb_cmd_master;

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        timeout;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int compared;
    int failed;

    ahb_cmd_master #(.TIMEOUT_CYC(4), .ADDR_W(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .timeout(timeout), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Slave model: 16-word memory, captures address phase, serves data phase
    logic [31:0] mem [0:15];
    logic        s_dvld;
    logic        s_dwrite;
    logic [3:0]  s_idx;

    // Slave pipeline register and write commit on each ready edge
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s_dvld   <= 1'b0;
            s_dwrite <= 1'b0;
            s_idx    <= 4'd0;
        end else if (hready_resp) begin
            if (s_dvld && s_dwrite) mem[s_idx] <= hwdata;
            s_dvld   <= hsel && (htrans == 2'b10);
            s_dwrite <= hwrite;
            s_idx    <= haddr[5:2];
        end
    end

    assign hrdata = (s_dvld && !s_dwrite) ? mem[s_idx] : 32'hDEAD_BEEF;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // Outputs while reset is asserted
    task automatic test_reset();
        #12;
        compared++; if (htrans !== 2'b00) begin failed++; $display("[TB] FAIL rst_htrans: got %h expected 0", htrans); end
        compared++; if (hsel !== 1'b0) begin failed++; $display("[TB] FAIL rst_hsel: got %b expected 0", hsel); end
        compared++; if (haddr !== 32'h0) begin failed++; $display("[TB] FAIL rst_haddr: got %h expected 0", haddr); end
        compared++; if (hwrite !== 1'b0) begin failed++; $display("[TB] FAIL rst_hwrite: got %b expected 0", hwrite); end
        compared++; if (hsize !== 3'b000) begin failed++; $display("[TB] FAIL rst_hsize: got %h expected 0", hsize); end
        compared++; if (hwdata !== 32'h0) begin failed++; $display("[TB] FAIL rst_hwdata: got %h expected 0", hwdata); end
        compared++; if (hburst !== 3'b000) begin failed++; $display("[TB] FAIL rst_hburst: got %h expected 0", hburst); end
        compared++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failed++; $display("[TB] FAIL rst_rsp: got v=%b e=%b d=%h expected all 0", rsp_valid, rsp_err, rsp_rdata); end
        compared++; if (timeout !== 1'b0) begin failed++; $display("[TB] FAIL rst_timeout: got %b expected 0", timeout); end
        compared++; if (cmd_ready !== 1'b1) begin failed++; $display("[TB] FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        step();
        hresetn = 1'b1;
        step();
    endtask

    // Single write then read of word 0x0 with zero wait states
    task automatic test_single();
        drive_cmd(1'b1, 2'd2, 32'h0, 32'h1122_3344);
        step();
        cmd_valid = 1'b0;
        compared++; if (htrans !== 2'b10 || hsel !== 1'b1) begin failed++; $display("[TB] FAIL single_wr_addr_phase: got htrans=%h hsel=%b expected 2 1", htrans, hsel); end
        compared++; if (haddr !== 32'h0 || hwrite !== 1'b1 || hsize !== 3'b010) begin failed++; $display("[TB] FAIL single_wr_ctrl: got a=%h w=%b s=%h expected 0 1 2", haddr, hwrite, hsize); end
        step();
        compared++; if (htrans !== 2'b00 || hsel !== 1'b0) begin failed++; $display("[TB] FAIL single_wr_idle: got htrans=%h hsel=%b expected 0 0", htrans, hsel); end
        compared++; if (hwdata !== 32'h1122_3344) begin failed++; $display("[TB] FAIL single_wr_hwdata: got %h expected 11223344", hwdata); end
        compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL single_wr_early_rsp: got %b expected 0", rsp_valid); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failed++; $display("[TB] FAIL single_wr_rsp: got v=%b d=%h e=%b expected 1 0 0", rsp_valid, rsp_rdata, rsp_err); end
        drive_cmd(1'b0, 2'd2, 32'h0, 32'h0);
        step();
        cmd_valid = 1'b0;
        compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL single_rsp_pulse: got %b expected 0", rsp_valid); end
        compared++; if (htrans !== 2'b10 || hwrite !== 1'b0) begin failed++; $display("[TB] FAIL single_rd_addr: got htrans=%h w=%b expected 2 0", htrans, hwrite); end
        step();
        compared++; if (hwdata !== 32'h1122_3344) begin failed++; $display("[TB] FAIL single_rd_hwdata_hold: got %h expected 11223344", hwdata); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344) begin failed++; $display("[TB] FAIL single_rd_rsp: got v=%b d=%h expected 1 11223344", rsp_valid, rsp_rdata); end
        step();
    endtask

    // Three writes then three reads in reverse order, one command per cycle
    task automatic test_back_to_back();
        logic        wr [6];
        logic [31:0] ad [6];
        logic [31:0] wd [6];
        logic [31:0] rd [6];
        wr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ad = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h4, 32'h0};
        wd = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'h0, 32'h0, 32'h0};
        rd = '{32'h0, 32'h0, 32'h0, 32'h99AA_BBCC, 32'h5566_7788, 32'h1122_3344};
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive_cmd(wr[i], 2'd2, ad[i], wd[i]);
            else cmd_valid = 1'b0;
            step();
            if (i < 6) begin
                compared++; if (htrans !== 2'b10 || haddr !== ad[i]) begin failed++; $display("[TB] FAIL b2b_addr%0d: got htrans=%h a=%h expected 2 %h", i, htrans, haddr, ad[i]); end
            end else if (i == 6) begin
                compared++; if (htrans !== 2'b00) begin failed++; $display("[TB] FAIL b2b_idle: got %h expected 0", htrans); end
            end
            if (i >= 1 && i <= 3) begin
                compared++; if (hwdata !== wd[i-1]) begin failed++; $display("[TB] FAIL b2b_hwdata%0d: got %h expected %h", i-1, hwdata, wd[i-1]); end
            end
            if (i >= 2) begin
                compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== rd[i-2]) begin failed++; $display("[TB] FAIL b2b_rsp%0d: got v=%b d=%h expected 1 %h", i-2, rsp_valid, rsp_rdata, rd[i-2]); end
            end
        end
        step();
        compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL b2b_drain: got %b expected 0", rsp_valid); end
    endtask

    // Address alignment and hsize encoding for byte, halfword and size 3
    task automatic test_size();
        drive_cmd(1'b0, 2'd0, 32'h7, 32'h0);
        step();
        compared++; if (haddr !== 32'h7 || hsize !== 3'b000) begin failed++; $display("[TB] FAIL size_byte: got a=%h s=%h expected 7 0", haddr, hsize); end
        drive_cmd(1'b0, 2'd1, 32'h3, 32'h0);
        step();
        compared++; if (haddr !== 32'h2 || hsize !== 3'b001) begin failed++; $display("[TB] FAIL size_half: got a=%h s=%h expected 2 1", haddr, hsize); end
        drive_cmd(1'b0, 2'd3, 32'h13, 32'h0);
        step();
        cmd_valid = 1'b0;
        compared++; if (haddr !== 32'h10 || hsize !== 3'b010) begin failed++; $display("[TB] FAIL size_three: got a=%h s=%h expected 10 2", haddr, hsize); end
        step(); step(); step();
    endtask

    // Three-cycle stall on read 0x4 with read 0x8 waiting in the address phase
    task automatic test_wait_states();
        drive_cmd(1'b0, 2'd2, 32'h4, 32'h0);
        step();
        drive_cmd(1'b0, 2'd2, 32'h8, 32'h0);
        step();
        drive_cmd(1'b0, 2'd2, 32'h0, 32'h0);
        hready_resp = 1'b0;
        #1;
        compared++; if (cmd_ready !== 1'b0 || hready !== 1'b0) begin failed++; $display("[TB] FAIL ws_ready: got cmd_ready=%b hready=%b expected 0 0", cmd_ready, hready); end
        for (int k = 0; k < 3; k++) begin
            step();
            compared++; if (haddr !== 32'h8 || htrans !== 2'b10 || hsel !== 1'b1 || hwdata !== 32'h99AA_BBCC) begin failed++; $display("[TB] FAIL ws_hold%0d: got a=%h t=%h s=%b wd=%h expected 8 2 1 99aabbcc", k, haddr, htrans, hsel, hwdata); end
            compared++; if (rsp_valid !== 1'b0 || timeout !== 1'b0 || cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL ws_quiet%0d: got v=%b to=%b rdy=%b expected 0 0 0", k, rsp_valid, timeout, cmd_ready); end
        end
        hready_resp = 1'b1;
        step();
        cmd_valid = 1'b0;
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5566_7788) begin failed++; $display("[TB] FAIL ws_rsp4: got v=%b d=%h expected 1 55667788", rsp_valid, rsp_rdata); end
        compared++; if (haddr !== 32'h0 || htrans !== 2'b10) begin failed++; $display("[TB] FAIL ws_next_addr: got a=%h t=%h expected 0 2", haddr, htrans); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h99AA_BBCC) begin failed++; $display("[TB] FAIL ws_rsp8: got v=%b d=%h expected 1 99aabbcc", rsp_valid, rsp_rdata); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344) begin failed++; $display("[TB] FAIL ws_rsp0: got v=%b d=%h expected 1 11223344", rsp_valid, rsp_rdata); end
        step();
    endtask

    // Five-cycle stall crosses the TIMEOUT_CYC=4 limit; flag stays set
    task automatic test_timeout();
        logic exp_to [5];
        exp_to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        drive_cmd(1'b1, 2'd2, 32'h0, 32'h1122_3344);
        step();
        cmd_valid = 1'b0;
        step();
        hready_resp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            compared++; if (timeout !== exp_to[k]) begin failed++; $display("[TB] FAIL to_stall%0d: got %b expected %b", k, timeout, exp_to[k]); end
        end
        hready_resp = 1'b1;
        step();
        compared++; if (rsp_valid !== 1'b1 || timeout !== 1'b1) begin failed++; $display("[TB] FAIL to_complete: got v=%b to=%b expected 1 1", rsp_valid, timeout); end
        step(); step();
        compared++; if (timeout !== 1'b1) begin failed++; $display("[TB] FAIL to_sticky: got %b expected 1", timeout); end
    endtask

    // Asynchronous reset in the middle of a data phase
    task automatic test_reset_mid();
        drive_cmd(1'b0, 2'd2, 32'h4, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        #2;
        hresetn = 1'b0;
        #1;
        compared++; if (htrans !== 2'b00 || hsel !== 1'b0 || haddr !== 32'h0) begin failed++; $display("[TB] FAIL rm_bus: got t=%h s=%b a=%h expected 0 0 0", htrans, hsel, haddr); end
        compared++; if (hwdata !== 32'h0 || timeout !== 1'b0) begin failed++; $display("[TB] FAIL rm_regs: got wd=%h to=%b expected 0 0", hwdata, timeout); end
        step();
        compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL rm_no_rsp: got %b expected 0", rsp_valid); end
        hresetn = 1'b1;
        step();
        compared++; if (rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL rm_no_rsp_after: got %b expected 0", rsp_valid); end
        drive_cmd(1'b0, 2'd2, 32'h8, 32'h0);
        step();
        cmd_valid = 1'b0;
        step(); step();
        compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h99AA_BBCC) begin failed++; $display("[TB] FAIL rm_recover: got v=%b d=%h expected 1 99aabbcc", rsp_valid, rsp_rdata); end
        step();
    endtask

`ifdef AHB_MST_ERR_RESP_EN
    // Two-cycle ERROR on write 0x10 with read 0x14 queued behind it
    task automatic test_err_resp();
        drive_cmd(1'b1, 2'd2, 32'h14, 32'hCAFE_F00D);
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        drive_cmd(1'b1, 2'd2, 32'h10, 32'h0BAD_F00D);
        step();
        drive_cmd(1'b0, 2'd2, 32'h14, 32'h0);
        step();
        cmd_valid   = 1'b0;
        hresp       = 2'b01;
        hready_resp = 1'b0;
        #1;
        compared++; if (htrans !== 2'b00 || hsel !== 1'b0) begin failed++; $display("[TB] FAIL err_cyc1: got t=%h s=%b expected 0 0", htrans, hsel); end
        step();
        hready_resp = 1'b1;
        #1;
        compared++; if (htrans !== 2'b00 || cmd_ready !== 1'b0) begin failed++; $display("[TB] FAIL err_cyc2: got t=%h rdy=%b expected 0 0", htrans, cmd_ready); end
        step();
        hresp = 2'b00;
        #1;
        compared++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failed++; $display("[TB] FAIL err_rsp: got v=%b e=%b d=%h expected 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
        compared++; if (htrans !== 2'b10 || haddr !== 32'h14) begin failed++; $display("[TB] FAIL err_reissue: got t=%h a=%h expected 2 14", htrans, haddr); end
        step();
        compared++; if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin failed++; $display("[TB] FAIL err_gap: got v=%b t=%h expected 0 0", rsp_valid, htrans); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin failed++; $display("[TB] FAIL err_retry_rsp: got v=%b e=%b d=%h expected 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata); end
        step();
    endtask
`else
    // ERROR responses are ignored in the default build
    task automatic test_hresp_ignored();
        drive_cmd(1'b1, 2'd2, 32'h10, 32'hA5A5_A5A5);
        step();
        drive_cmd(1'b0, 2'd2, 32'h0, 32'h0);
        step();
        cmd_valid = 1'b0;
        hresp     = 2'b01;
        #1;
        compared++; if (htrans !== 2'b10 || hsel !== 1'b1) begin failed++; $display("[TB] FAIL ign_htrans: got t=%h s=%b expected 2 1", htrans, hsel); end
        step();
        hresp = 2'b00;
        compared++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failed++; $display("[TB] FAIL ign_wr_rsp: got v=%b e=%b d=%h expected 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        step();
        compared++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1122_3344) begin failed++; $display("[TB] FAIL ign_rd_rsp: got v=%b e=%b d=%h expected 1 0 11223344", rsp_valid, rsp_err, rsp_rdata); end
        step();
    endtask
`endif

    // Scenario sequence
    initial begin
        compared    = 0;
        failed      = 0;
        hresetn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_size    = 2'd0;
        cmd_addr    = 32'h0;
        cmd_wdata   = 32'h0;
        hready_resp = 1'b1;
        hresp       = 2'b00;
        test_reset();
        test_single();
        test_back_to_back();
        test_size();
        test_wait_states();
        test_timeout();
        test_reset_mid();
`ifdef AHB_MST_ERR_RESP_EN
        test_err_resp();
`else
        test_hresp_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
